// File: rtl/bcd_pkg.sv
// Shared types and elaboration-time helpers for the sequential binary-to-BCD converter.
package bcd_pkg;

  localparam int unsigned BCD_DIGIT_W = 4;

  typedef enum logic [1:0] {
    IDLE,
    SHIFT,
    DONE
  } bcd_state_t;

  // 10**n as a 64-bit constant; wide enough for 10**9 compared against a 33-bit input range.
  function automatic logic [63:0] pow10(input int unsigned n);
    logic [63:0] r;
    r = 64'd1;
    for (int unsigned i = 0; i < n; i++) r = r * 64'd10;
    return r;
  endfunction

endpackage

// File: rtl/bin_to_bcd_seq_if.sv
// Valid/ready request and result channels of bin_to_bcd_seq.
// Port blank exists only when BIN2BCD_BLANK_EN is defined.
interface bin_to_bcd_seq_if
  import bcd_pkg::*;
#(
  parameter int unsigned BIN_W  = 16,
  parameter int unsigned DIGITS = 5
);
  logic                            in_valid;
  logic                            in_ready;
  logic [BIN_W-1:0]                bin;
  logic                            out_valid;
  logic                            out_ready;
  logic [BCD_DIGIT_W*DIGITS-1:0]   bcd;
  logic                            ovf;
`ifdef BIN2BCD_BLANK_EN
  logic [DIGITS-1:0]               blank;
`endif

  modport slave (
    input  in_valid, bin, out_ready,
    output in_ready, out_valid, bcd, ovf
`ifdef BIN2BCD_BLANK_EN
    , output blank
`endif
  );

  modport master (
    output in_valid, bin, out_ready,
    input  in_ready, out_valid, bcd, ovf
`ifdef BIN2BCD_BLANK_EN
    , input blank
`endif
  );

endinterface

// File: rtl/bcd_digit_adj.sv
// One BCD digit correction step: add 3 when the digit is 5 or more, before the left shift.
module bcd_digit_adj
  import bcd_pkg::*;
(
  input  logic [BCD_DIGIT_W-1:0] din,
  output logic [BCD_DIGIT_W-1:0] dout
);

  assign dout = (din >= BCD_DIGIT_W'(5)) ? din + BCD_DIGIT_W'(3) : din;

endmodule

// File: rtl/bin_to_bcd_seq.sv
// Sequential shift-and-add-3 binary-to-BCD converter, one input bit per clock, with saturation.
// Optional leading-zero mask output enabled by BIN2BCD_BLANK_EN.
module bin_to_bcd_seq
  import bcd_pkg::*;
#(
  parameter int unsigned BIN_W  = 16,
  parameter int unsigned DIGITS = 5
)(
  input  logic              clk,
  input  logic              rst_n,
  bin_to_bcd_seq_if.slave   io
);

  localparam int unsigned BCD_W     = BCD_DIGIT_W * DIGITS;
  localparam int unsigned CNT_W     = $clog2(BIN_W + 1);
  localparam logic [63:0] OVF_LIMIT = pow10(DIGITS);
  // When 10**DIGITS exceeds the input range no input can overflow.
  localparam bit          OVF_EN    = (OVF_LIMIT <= (64'd1 << BIN_W));
  localparam logic [BCD_W-1:0] ALL_NINES = {DIGITS{4'h9}};

  bcd_state_t        state_q, state_d;
  logic [BIN_W-1:0]  sh_q, sh_d;
  logic [BCD_W-1:0]  acc_q, acc_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic              ovf_pend_q, ovf_pend_d;
  logic [BCD_W-1:0]  bcd_q, bcd_d;
  logic              ovf_q, ovf_d;
  logic              out_valid_q, out_valid_d;

  logic [BCD_W-1:0]  adj;
  logic [BCD_W-1:0]  acc_sh;
  logic              accept;
  logic              ovf_in;

  for (genvar g = 0; g < DIGITS; g++) begin : g_adj
    bcd_digit_adj u_adj (
      .din  (acc_q[g*BCD_DIGIT_W +: BCD_DIGIT_W]),
      .dout (adj[g*BCD_DIGIT_W +: BCD_DIGIT_W])
    );
  end

  // Carry out of the top digit falls off the shift.
  assign acc_sh = (adj << 1) | BCD_W'(sh_q[BIN_W-1]);
  assign ovf_in = OVF_EN && (64'(io.bin) >= OVF_LIMIT);

  assign io.in_ready  = (state_q == IDLE) || ((state_q == DONE) && io.out_ready);
  assign accept       = io.in_valid && io.in_ready;
  assign io.out_valid = out_valid_q;
  assign io.bcd       = bcd_q;
  assign io.ovf       = ovf_q;

`ifdef BIN2BCD_BLANK_EN
  logic [DIGITS-1:0] blank_q, blank_d;
  logic [DIGITS-1:0] zmask;
  logic              all_zero;

  // zmask[i] set when digit i and every digit above it are zero; digit 0 never blanks.
  always_comb begin
    zmask    = '0;
    all_zero = 1'b1;
    for (int i = int'(DIGITS) - 1; i >= 1; i--) begin
      all_zero = all_zero && (acc_sh[i*BCD_DIGIT_W +: BCD_DIGIT_W] == BCD_DIGIT_W'(0));
      zmask[i] = all_zero;
    end
  end

  assign io.blank = blank_q;
`endif

  always_comb begin
    state_d     = state_q;
    sh_d        = sh_q;
    acc_d       = acc_q;
    cnt_d       = cnt_q;
    ovf_pend_d  = ovf_pend_q;
    bcd_d       = bcd_q;
    ovf_d       = ovf_q;
    out_valid_d = out_valid_q;
`ifdef BIN2BCD_BLANK_EN
    blank_d     = blank_q;
`endif

    case (state_q)
      IDLE: ;
      SHIFT: begin
        sh_d  = sh_q << 1;
        acc_d = acc_sh;
        cnt_d = cnt_q - CNT_W'(1);
        if (cnt_q == CNT_W'(1)) begin
          state_d     = DONE;
          out_valid_d = 1'b1;
          ovf_d       = ovf_pend_q;
          bcd_d       = ovf_pend_q ? ALL_NINES : acc_sh;
`ifdef BIN2BCD_BLANK_EN
          blank_d     = ovf_pend_q ? '0 : zmask;
`endif
        end
      end
      DONE: begin
        if (io.out_ready) begin
          out_valid_d = 1'b0;
          state_d     = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase

    // A new request may be taken from IDLE or back-to-back from an accepted DONE.
    if (accept) begin
      state_d    = SHIFT;
      sh_d       = io.bin;
      acc_d      = '0;
      cnt_d      = CNT_W'(BIN_W);
      ovf_pend_d = ovf_in;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= IDLE;
    else        state_q <= state_d;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sh_q        <= '0;
      acc_q       <= '0;
      cnt_q       <= '0;
      ovf_pend_q  <= 1'b0;
      bcd_q       <= '0;
      ovf_q       <= 1'b0;
      out_valid_q <= 1'b0;
    end else begin
      sh_q        <= sh_d;
      acc_q       <= acc_d;
      cnt_q       <= cnt_d;
      ovf_pend_q  <= ovf_pend_d;
      bcd_q       <= bcd_d;
      ovf_q       <= ovf_d;
      out_valid_q <= out_valid_d;
    end
  end

`ifdef BIN2BCD_BLANK_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) blank_q <= '0;
    else        blank_q <= blank_d;
  end
`endif

endmodule

// File: tb/tb_bin_to_bcd_seq.sv
// Self-checking bench for bin_to_bcd_seq: 5-digit and 4-digit instances, table vectors plus
// stall, back-to-back and reset-in-flight sequences, results checked through a scoreboard.
module tb_bin_to_bcd_seq;

  typedef struct packed {
    logic [19:0] bcd;
    logic        ovf;
    logic [4:0]  blank;
  } exp_t;

  typedef struct {
    bit          w;
    int unsigned bin;
    exp_t        e;
  } vec_t;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  bin_to_bcd_seq_if #(.BIN_W(16), .DIGITS(5)) if5 ();
  bin_to_bcd_seq_if #(.BIN_W(16), .DIGITS(4)) if4 ();

  bin_to_bcd_seq #(.BIN_W(16), .DIGITS(5)) dut5 (.clk(clk), .rst_n(rst_n), .io(if5));
  bin_to_bcd_seq #(.BIN_W(16), .DIGITS(4)) dut4 (.clk(clk), .rst_n(rst_n), .io(if4));

  exp_t q5[$];
  exp_t q4[$];
  vec_t tbl[15];
  int   total = 0;
  int   bad   = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  function automatic vec_t mk(input bit w, input int unsigned b, input logic [19:0] bcd,
                              input logic ovf, input logic [4:0] blank);
    vec_t v;
    v.w = w; v.bin = b; v.e.bcd = bcd; v.e.ovf = ovf; v.e.blank = blank;
    return v;
  endfunction

  // Reference by repeated division; w=1 selects the 4-digit instance.
  function automatic exp_t model(input bit w, input int unsigned b);
    exp_t        e;
    int unsigned nd, lim, v, p;
    e   = '0;
    nd  = w ? 4 : 5;
    lim = w ? 10000 : 100000;
    v   = b;
    p   = 10;
    if (b >= lim) begin
      for (int i = 0; i < int'(nd); i++) e.bcd[i*4 +: 4] = 4'h9;
      e.ovf = 1'b1;
    end else begin
      for (int i = 0; i < int'(nd); i++) begin
        e.bcd[i*4 +: 4] = 4'(v % 10);
        v = v / 10;
      end
      for (int i = 1; i < int'(nd); i++) begin
        e.blank[i] = (b < p);
        p = p * 10;
      end
    end
    return e;
  endfunction

  task automatic drive(input bit w, input logic v, input logic [15:0] b, input logic r);
    if (w) begin if4.in_valid = v; if4.bin = b; if4.out_ready = r; end
    else   begin if5.in_valid = v; if5.bin = b; if5.out_ready = r; end
  endtask

  task automatic sample(input bit w, output logic ov, output logic ir, output logic [19:0] bcd,
                        output logic ovf, output logic [4:0] bl);
    bl = '0;
    if (w) begin
      ov = if4.out_valid; ir = if4.in_ready; bcd = {4'h0, if4.bcd}; ovf = if4.ovf;
`ifdef BIN2BCD_BLANK_EN
      bl = {1'b0, if4.blank};
`endif
    end else begin
      ov = if5.out_valid; ir = if5.in_ready; bcd = if5.bcd; ovf = if5.ovf;
`ifdef BIN2BCD_BLANK_EN
      bl = if5.blank;
`endif
    end
  endtask

  // Counts edges from the accepting edge until out_valid, bounded.
  task automatic wait_out(input bit w, input string name);
    logic ov, ir, ovf; logic [19:0] bcd; logic [4:0] bl;
    int n;
    n = 0; ov = 1'b0;
    while (!ov && n < 40) begin
      @(posedge clk); #1;
      n++;
      sample(w, ov, ir, bcd, ovf, bl);
    end
    check({name, "_out_valid"}, 32'(ov), 32'd1);
    check({name, "_latency"}, 32'(n), 32'd16);
  endtask

  task automatic pop_check(input bit w, input string name);
    logic ov, ir, ovf; logic [19:0] bcd; logic [4:0] bl;
    exp_t e;
    sample(w, ov, ir, bcd, ovf, bl);
    if ((w ? q4.size() : q5.size()) == 0) begin
      total++; bad++;
      $display("FAIL %s_sb: got result with empty scoreboard", name);
      return;
    end
    e = w ? q4.pop_front() : q5.pop_front();
    check({name, "_valid"}, 32'(ov), 32'd1);
    check({name, "_bcd"}, 32'(bcd), 32'(e.bcd));
    check({name, "_ovf"}, 32'(ovf), 32'(e.ovf));
`ifdef BIN2BCD_BLANK_EN
    check({name, "_blank"}, 32'(bl), 32'(e.blank));
`endif
  endtask

  // One full transaction from IDLE; returns with the DUT back in IDLE.
  task automatic xfer(input bit w, input logic [15:0] b, input exp_t e, input string name);
    logic ov, ir, ovf; logic [19:0] bcd; logic [4:0] bl;
    drive(w, 1'b1, b, 1'b0);
    #1;
    sample(w, ov, ir, bcd, ovf, bl);
    check({name, "_in_ready"}, 32'(ir), 32'd1);
    if (w) q4.push_back(e); else q5.push_back(e);
    @(posedge clk); #1;
    drive(w, 1'b0, ~b, 1'b0);
    wait_out(w, name);
    drive(w, 1'b0, 16'h0, 1'b1);
    #1;
    pop_check(w, name);
    @(posedge clk); #1;
    drive(w, 1'b0, 16'h0, 1'b0);
    sample(w, ov, ir, bcd, ovf, bl);
    check({name, "_valid_drop"}, 32'(ov), 32'd0);
  endtask

  initial begin
    logic ov, ir, ovf; logic [19:0] bcd; logic [4:0] bl;
    logic [15:0] rb;
    bit rw;

    tbl[0]  = mk(1'b0, 0,     20'h00000, 1'b0, 5'b11110);
    tbl[1]  = mk(1'b0, 12345, 20'h12345, 1'b0, 5'b00000);
    tbl[2]  = mk(1'b0, 65535, 20'h65535, 1'b0, 5'b00000);
    tbl[3]  = mk(1'b0, 42,    20'h00042, 1'b0, 5'b11100);
    tbl[4]  = mk(1'b0, 9,     20'h00009, 1'b0, 5'b11110);
    tbl[5]  = mk(1'b0, 10,    20'h00010, 1'b0, 5'b11100);
    tbl[6]  = mk(1'b0, 999,   20'h00999, 1'b0, 5'b11000);
    tbl[7]  = mk(1'b0, 1000,  20'h01000, 1'b0, 5'b10000);
    tbl[8]  = mk(1'b0, 99,    20'h00099, 1'b0, 5'b11100);
    tbl[9]  = mk(1'b1, 10000, 20'h09999, 1'b1, 5'b00000);
    tbl[10] = mk(1'b1, 9999,  20'h09999, 1'b0, 5'b00000);
    tbl[11] = mk(1'b1, 65535, 20'h09999, 1'b1, 5'b00000);
    tbl[12] = mk(1'b1, 1234,  20'h01234, 1'b0, 5'b00000);
    tbl[13] = mk(1'b1, 0,     20'h00000, 1'b0, 5'b01110);
    tbl[14] = mk(1'b1, 50,    20'h00050, 1'b0, 5'b01100);

    rst_n = 1'b0;
    drive(1'b0, 1'b0, 16'h0, 1'b0);
    drive(1'b1, 1'b0, 16'h0, 1'b0);
    repeat (3) @(posedge clk);
    #1;
    for (int d = 0; d < 2; d++) begin
      sample(d[0], ov, ir, bcd, ovf, bl);
      check("reset_out_valid", 32'(ov), 32'd0);
      check("reset_bcd", 32'(bcd), 32'd0);
      check("reset_ovf", 32'(ovf), 32'd0);
      check("reset_blank", 32'(bl), 32'd0);
    end
    rst_n = 1'b1;
    @(posedge clk); #1;
    sample(1'b0, ov, ir, bcd, ovf, bl);
    check("reset_in_ready", 32'(ir), 32'd1);

    for (int i = 0; i < 15; i++)
      xfer(tbl[i].w, 16'(tbl[i].bin), tbl[i].e, $sformatf("vec%0d", i));

    for (int i = 0; i < 6; i++) begin
      rb = 16'($urandom_range(0, 65535));
      rw = 1'($urandom_range(0, 1));
      xfer(rw, rb, model(rw, 32'(rb)), $sformatf("rnd%0d", i));
    end

    // Long stall in DONE, then back-to-back acceptance of the next request.
    drive(1'b0, 1'b1, 16'd12345, 1'b0);
    q5.push_back(model(1'b0, 12345));
    @(posedge clk); #1;
    drive(1'b0, 1'b0, 16'h0, 1'b0);
    wait_out(1'b0, "stall");
    drive(1'b0, 1'b1, 16'd99, 1'b0);
    for (int i = 0; i < 10; i++) begin
      @(posedge clk); #1;
      sample(1'b0, ov, ir, bcd, ovf, bl);
      check("stall_valid", 32'(ov), 32'd1);
      check("stall_bcd", 32'(bcd), 32'h12345);
      check("stall_in_ready", 32'(ir), 32'd0);
    end
    drive(1'b0, 1'b1, 16'd99, 1'b1);
    #1;
    sample(1'b0, ov, ir, bcd, ovf, bl);
    check("b2b_in_ready", 32'(ir), 32'd1);
    pop_check(1'b0, "stall_result");
    q5.push_back(model(1'b0, 99));
    @(posedge clk); #1;
    drive(1'b0, 1'b0, 16'd7777, 1'b0);
    sample(1'b0, ov, ir, bcd, ovf, bl);
    check("b2b_valid_low", 32'(ov), 32'd0);
    check("b2b_busy", 32'(ir), 32'd0);
    wait_out(1'b0, "b2b");
    drive(1'b0, 1'b0, 16'h0, 1'b1);
    #1;
    pop_check(1'b0, "b2b_result");
    @(posedge clk); #1;
    drive(1'b0, 1'b0, 16'h0, 1'b0);

    // Reset five edges into SHIFT abandons the conversion.
    drive(1'b0, 1'b1, 16'd12345, 1'b0);
    @(posedge clk); #1;
    drive(1'b0, 1'b0, 16'h0, 1'b0);
    repeat (4) @(posedge clk);
    #1;
    rst_n = 1'b0;
    #1;
    sample(1'b0, ov, ir, bcd, ovf, bl);
    check("rst_shift_valid", 32'(ov), 32'd0);
    check("rst_shift_bcd", 32'(bcd), 32'd0);
    repeat (3) @(posedge clk);
    #1;
    rst_n = 1'b1;
    #1;
    sample(1'b0, ov, ir, bcd, ovf, bl);
    check("rst_release_in_ready", 32'(ir), 32'd1);
    for (int i = 0; i < 20; i++) begin
      @(posedge clk); #1;
      sample(1'b0, ov, ir, bcd, ovf, bl);
      if (ov) check("rst_no_stale_valid", 32'(ov), 32'd0);
    end
    xfer(1'b0, 16'd42, model(1'b0, 42), "post_rst");

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
